// File: rtl/controlador_carga_pkg.sv
// Shared types and constants for the load controller: FSM state encoding and debounce counter width.
package controlador_carga_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    DESLIGADO = 1'b0,
    LIGADO    = 1'b1
  } estado_t;

endpackage

// File: rtl/controlador_carga_if.sv
// Pushbutton / timer / sensor inputs and load outputs of the load controller.
interface controlador_carga_if;
  import controlador_carga_pkg::*;

  logic botao;
  logic C;
  logic infravermelho;
  logic enable;
  logic lampada;
  logic desligou_auto;

  modport master (
    output botao, C, infravermelho,
    input  enable, lampada, desligou_auto
  );

  modport slave (
    input  botao, C, infravermelho,
    output enable, lampada, desligou_auto
  );
endinterface

// File: rtl/controlador_carga_debounce.sv
// Pushbutton debouncer: one-cycle pulso after DEBOUNCE_T consecutive high samples, re-armed by a low sample.
module debounce_botao
  import controlador_carga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_T = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_T);

  logic [CNT_W-1:0] cnt;
  logic             armado;
  // Cleared by reset: a press already held through reset must see botao low before counting.
  logic             liberado;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      armado   <= 1'b1;
      liberado <= 1'b0;
    end else if (!botao) begin
      cnt      <= '0;
      armado   <= 1'b1;
      liberado <= 1'b1;
    end else begin
      if (liberado && (cnt != '1))
        cnt <= cnt + 1'b1;
      if (pulso)
        armado <= 1'b0;
    end
  end

  assign pulso = armado && (cnt == LIMITE);

endmodule

// File: rtl/controlador_carga.sv
// Manual/auto-off load controller. Define CONTROLADOR_CARGA_AUTO_ON_EN to let a
// rising edge of infravermelho switch the load on while it is off.
module controlador_carga
  import controlador_carga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_T = 300
) (
  input logic              clk,
  input logic              rst,
  controlador_carga_if.slave bus
);

  estado_t estado, estado_prox;
  logic    pulso;
  logic    ir_sobe;
  logic    desligou_q;
  logic    desligou_prox;

  debounce_botao #(.DEBOUNCE_T(DEBOUNCE_T)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .botao (bus.botao),
    .pulso (pulso)
  );

`ifdef CONTROLADOR_CARGA_AUTO_ON_EN
  // Previous sample resets high so presence already asserted at reset is not an edge.
  logic ir_ant;

  always_ff @(posedge clk) begin
    if (rst) ir_ant <= 1'b1;
    else     ir_ant <= bus.infravermelho;
  end

  assign ir_sobe = bus.infravermelho && !ir_ant;
`else
  logic ir_unused;
  assign ir_unused = bus.infravermelho;
  assign ir_sobe   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= DESLIGADO;
      desligou_q <= 1'b0;
    end else begin
      estado     <= estado_prox;
      desligou_q <= desligou_prox;
    end
  end

  always_comb begin
    estado_prox   = estado;
    desligou_prox = 1'b0;
    unique case (estado)
      DESLIGADO: if (pulso || ir_sobe) estado_prox = LIGADO;
      LIGADO: begin
        if (pulso || bus.C) estado_prox = DESLIGADO;
        desligou_prox = bus.C;
      end
      default: estado_prox = DESLIGADO;
    endcase
  end

  always_comb begin
    bus.lampada       = (estado == LIGADO);
    bus.enable        = (estado == LIGADO);
    bus.desligou_auto = desligou_q;
  end

endmodule

// File: doc/controlador_carga.md
CONTROLADOR_CARGA -- requirements
Module: controlador_carga

Interface
REQ-001 Parameter DEBOUNCE_T, default 300, SHALL set the number of consecutive cycles botao must be sampled high before a press is accepted (1..65535).
REQ-002 Port clk, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be a synchronous active-high reset.
REQ-004 Port botao, input, 1, SHALL be the raw manual on/off pushbutton, high while pressed.
REQ-005 Port C, input, 1, SHALL be the auto-shutdown pulse from the inactivity timer, high for one cycle per timeout.
REQ-006 Port infravermelho, input, 1, SHALL be the presence sensor, high while presence is detected.
REQ-007 Port enable, output, 1, SHALL enable the inactivity timer; high exactly while the load is on.
REQ-008 Port lampada, output, 1, SHALL drive the load; registered.
REQ-009 Port desligou_auto, output, 1, SHALL pulse high for one cycle when the load is switched off by C.

Function
REQ-010 Debouncer SHALL keep a 16-bit saturating counter, incremented each cycle botao=1 and cleared on any cycle botao=0.
REQ-011 Debouncer SHALL emit an internal one-cycle press pulse in the cycle the counter reaches DEBOUNCE_T, then no further pulse until botao has been sampled low.
REQ-012 Main FSM SHALL have exactly two states: DESLIGADO (lampada=0) and LIGADO (lampada=1).
REQ-013 DESLIGADO -> LIGADO SHALL occur on a press pulse; lampada rises one cycle after the pulse.
REQ-014 LIGADO -> DESLIGADO SHALL occur on a press pulse or on C=1; lampada falls one cycle later.
REQ-015 desligou_auto SHALL be 1 in the cycle lampada falls only if C=1 caused the transition, including when press and C coincide.
REQ-016 C in DESLIGADO SHALL be ignored; press and C coinciding in DESLIGADO SHALL turn the load on.
REQ-017 enable SHALL equal lampada in every cycle.
REQ-018 A press held indefinitely SHALL toggle the load once only.

Reset
REQ-019 With rst=1 at a clock edge: state SHALL go to DESLIGADO, counter to 0, re-arm flag to armed, lampada=0, enable=0, desligou_auto=0, all effective the following cycle.
REQ-020 Reset SHALL take priority over press, C and infravermelho in the same cycle; a press in progress at reset SHALL be discarded until botao is seen low.

Configuration
REQ-021 With macro CONTROLADOR_CARGA_AUTO_ON_EN defined, a rising edge of infravermelho (0 then 1 on consecutive samples) in DESLIGADO SHALL turn the load on one cycle later, identical to a press.
REQ-022 The infravermelho edge detector SHALL reset to previous-sample=1, so presence already high at reset does not turn the load on.
REQ-023 Without the macro, infravermelho SHALL have no effect, and no edge-detect register SHALL be synthesised.

Structure
REQ-024 A shared package SHALL hold the FSM state enum (DESLIGADO, LIGADO) and the 16-bit counter width constant.
REQ-025 The debouncer SHALL be a separate sub-module debounce_botao (clk, rst, botao -> pulso), parameterised by DEBOUNCE_T.

Verification
REQ-026 DEBOUNCE_T=4: botao high 3 cycles, low, high 3 cycles -> lampada stays 0.
REQ-027 DEBOUNCE_T=4: botao high 10 cycles -> one pulse at the 4th high sample, lampada=1 one cycle later, enable=1; a second 10-cycle press -> lampada=0, desligou_auto=0.
REQ-028 Load on, C=1 for one cycle -> lampada=0 and desligou_auto=1 next cycle; C while off -> no change.
REQ-029 Load on, press pulse and C in the same cycle -> lampada=0, desligou_auto=1; load off, same coincidence -> lampada=1.
REQ-030 rst=1 mid-press at counter=2 with botao held high -> lampada=0 and no toggle until botao is released and pressed again.
REQ-031 With CONTROLADOR_CARGA_AUTO_ON_EN: infravermelho high from reset -> stays off; infravermelho 0->1 while off -> lampada=1 next cycle. Without the macro, the same stimulus -> lampada stays 0.
